// File: rtl/alu_seq.sv
// Command sequencer and writeback stage around an external combinational 4-bit ALU.
// Define ALU_SEQ_FIFO_EN for a 4-deep command FIFO; otherwise a single holding register.
module alu_seq (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [3:0] i_cmd_mode,
  input  logic [1:0] i_cmd_src1,
  input  logic [1:0] i_cmd_src2,
  input  logic [1:0] i_cmd_dst,
  input  logic [3:0] i_cmd_imm,
  input  logic       i_cmd_usec,
  output logic [3:0] o_alu_E,
  output logic [3:0] o_alu_mode,
  output logic [3:0] o_alu_op1,
  output logic [3:0] o_alu_op2,
  output logic       o_alu_cflag,
  input  logic [7:0] i_alu_result,
  input  logic [3:0] i_alu_flags,
  output logic       o_res_valid,
  input  logic       i_res_ready,
  output logic [7:0] o_res_data,
  output logic [3:0] o_res_flags,
  output logic [3:0] o_flags
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_ALU  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_CLRF = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  localparam int unsigned CMD_W = 17;

  // Command word layout: {op, mode, src1, src2, dst, imm, usec}
  logic [CMD_W-1:0] cmd_in;
  logic [CMD_W-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign cmd_in = {i_cmd_op, i_cmd_mode, i_cmd_src1, i_cmd_src2, i_cmd_dst,
                   i_cmd_imm, i_cmd_usec};

  assign o_cmd_ready = !fifo_full && !i_rst;
  assign push        = i_cmd_valid && o_cmd_ready;

`ifdef ALU_SEQ_FIFO_EN
  logic [CMD_W-1:0] mem_q [4];
  logic [CMD_W-1:0] mem_d [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [CMD_W-1:0] hold_q, hold_d;
  logic             occ_q, occ_d;

  assign fifo_full  = occ_q;
  assign fifo_empty = !occ_q;
  assign fifo_head  = hold_q;

  // Push is only possible while empty, so push and pop never coincide here.
  always_comb begin
    hold_d = hold_q;
    occ_d  = occ_q;
    if (pop) occ_d = 1'b0;
    if (push) begin
      hold_d = cmd_in;
      occ_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
      occ_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      occ_q  <= occ_d;
    end
  end
`endif

  logic [1:0]       state_q, state_d;
  logic [CMD_W-1:0] ir_q, ir_d;
  logic [3:0]       regs_q [4];
  logic [3:0]       regs_d [4];
  logic [3:0]       flags_q, flags_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [3:0]       res_flags_q, res_flags_d;

  logic [1:0] ir_op;
  logic [3:0] ir_mode;
  logic [1:0] ir_src1;
  logic [1:0] ir_src2;
  logic [1:0] ir_dst;
  logic [3:0] ir_imm;
  logic       ir_usec;
  logic       exec_alu;

  assign {ir_op, ir_mode, ir_src1, ir_src2, ir_dst, ir_imm, ir_usec} = ir_q;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          ir_d    = fifo_head;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        case (ir_op)
          OP_ALU: begin
            regs_d[ir_dst] = i_alu_result[3:0];
            flags_d        = i_alu_flags;
            res_data_d     = i_alu_result;
          end
          OP_LOAD: begin
            regs_d[ir_dst] = ir_imm;
            res_data_d     = {4'h0, ir_imm};
          end
          OP_CLRF: begin
            flags_d    = 4'h0;
            res_data_d = 8'h00;
          end
          default: res_data_d = 8'h00;
        endcase
        res_flags_d = flags_d;
      end
      ST_RESP: begin
        if (i_res_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            ir_d    = fifo_head;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
      flags_q     <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

  // ALU drive is only live for an ALU command in EXEC; operands are read before writeback.
  assign exec_alu    = (state_q == ST_EXEC) && (ir_op == OP_ALU);
  assign o_alu_E     = exec_alu ? 4'hF : 4'h0;
  assign o_alu_mode  = exec_alu ? ir_mode : 4'h0;
  assign o_alu_op1   = exec_alu ? regs_q[ir_src1] : 4'h0;
  assign o_alu_op2   = exec_alu ? regs_q[ir_src2] : 4'h0;
  assign o_alu_cflag = exec_alu && ir_usec && flags_q[3];

  assign o_res_valid = (state_q == ST_RESP);
  assign o_res_data  = res_data_q;
  assign o_res_flags = res_flags_q;
  assign o_flags     = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer and writeback stage wrapped around the combinational 4-bit ALU. It accepts operation commands over a valid/ready handshake and buffers them. For each command it reads operands from a four-entry 4-bit register file and drives the ALU's mode, operand and carry-in inputs. It then captures the ALU's 8-bit result and 4-bit flags, writes back, and presents the result downstream with backpressure. The flag register is the carry source for add-with-carry and subtract-with-borrow chains.

## Interface
- No parameters; FIFO depth is selected by the configuration macro.
- i_clk  in  1  clock, rising-edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted on an edge where valid and ready are both high.
- i_cmd_op  in  2  command type: 00 ALU, 01 LOAD immediate, 10 CLRF (clear flags), 11 NOP.
- i_cmd_mode  in  4  ALU mode, passed unchanged to the ALU.
- i_cmd_src1, i_cmd_src2, i_cmd_dst  in  2 each  register indices R0–R3.
- i_cmd_imm  in  4  immediate for LOAD.
- i_cmd_usec  in  1  1: ALU carry-in = flag[3]; 0: carry-in = 0.
- o_alu_E  out  4  4'hF while an ALU command executes, else 4'h0.
- o_alu_mode, o_alu_op1, o_alu_op2  out  4 each  ALU inputs.
- o_alu_cflag  out  1  ALU carry-in.
- i_alu_result  in  8  ALU result.
- i_alu_flags  in  4  ALU flags: [0] zero, [1] sign (result[7]), [2] overflow, [3] carry/borrow.
- o_res_valid  out  1  response valid.
- i_res_ready  in  1  response accepted on an edge where valid and ready are both high.
- o_res_data  out  8  response result.
- o_res_flags  out  4  flag register value after the command.
- o_flags  out  4  live flag register.

## Operation
- Accepted commands enter the command FIFO, which pops in order. o_cmd_ready = !full.
  - A push and a pop on the same edge are both performed when the FIFO is not full.
  - A full FIFO refuses the push even if a pop occurs on that edge.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: FIFO non-empty → pop into the instruction register, go to EXEC.
  - EXEC: lasts exactly one cycle. Operands are read from the register file and all results are registered at the end of the cycle; always goes to RESP.
  - RESP: o_res_valid = 1. On handshake with FIFO non-empty → pop, go to EXEC. On handshake with FIFO empty → IDLE. Without handshake → stay in RESP.
- EXEC actions by command type:
  - ALU: o_alu_op1 = R[src1], o_alu_op2 = R[src2], o_alu_cflag = usec & flag[3]. At the end of EXEC: R[dst] ← i_alu_result[3:0], flags ← i_alu_flags, o_res_data ← i_alu_result (full 8 bits).
  - LOAD: R[dst] ← imm, flags unchanged, o_res_data ← {4'h0, imm}.
  - CLRF: flags ← 4'h0, o_res_data ← 8'h00.
  - NOP: no state change, o_res_data ← 8'h00.
  - For any non-ALU command, o_alu_E = 0.
- src and dst may name the same register. Operands are read before writeback, so R1 = R1 + R1 uses the old R1.
- ALU outputs (o_alu_*) are zero whenever the block is not in EXEC.
- Commands are serialised, so there are no read-after-write hazards.

## Timing
- Reset values: all registers R0–R3 = 0, flags = 0, FSM = IDLE, FIFO empty, o_res_valid = 0, o_res_data = 0, o_res_flags = 0, o_flags = 0, all o_alu_* = 0.
  - o_cmd_ready = 0 while i_rst is high and 1 in the first cycle after release.
- Latency, for a command accepted at edge N into an empty, idle block:
  - IDLE pops at edge N+1.
  - EXEC runs in cycle N+1→N+2.
  - o_res_valid is high from cycle N+2.
- Throughput: one command per 2 cycles when i_res_ready is held high.
- o_res_data and o_res_flags are stable while o_res_valid = 1 and the response is not yet accepted.
- o_flags changes only at the end of EXEC.
- An i_rst assertion mid-operation immediately discards FIFO contents, the command in flight and any pending response. Outputs return to their reset values.

## Configuration
- ALU_SEQ_FIFO_EN defined: the command FIFO is 4 entries deep with a 2-bit wrap-around pointer and a 3-bit count.
- ALU_SEQ_FIFO_EN undefined: the FIFO is a single-entry holding register, and o_cmd_ready = !occupied.
- All other behaviour is identical in both builds.

## Test plan
- Load and add: LOAD R0 = 9, LOAD R1 = 8, then ALU mode 0000 with src1 = 0, src2 = 1, dst = 2, usec = 0 → o_res_data = 8'h11, o_res_flags = 4'b1100, R2 = 1.
- Carry chain: after the add above, the same ALU command with usec = 1 → o_alu_cflag = 1, o_res_data = 8'h12. Then CLRF, then repeat the command with usec = 1 → o_alu_cflag = 0, o_res_data = 8'h11.
- Backpressure: hold i_res_ready = 0 and push 6 commands.
  - o_res_data stays stable while o_res_valid is held.
  - o_cmd_ready drops after 5 accepts with ALU_SEQ_FIFO_EN defined (1 in EXEC/RESP plus 4 buffered), or after 2 accepts without it.
  - On release, all responses arrive in order.
- Streaming: i_res_ready = 1 with 8 back-to-back LOAD commands (imm = 0..7) → o_res_valid pulses every 2 cycles, o_res_data = 8'h00 … 8'h07 in order.
- Reset mid-operation: assert i_rst while in EXEC with 3 commands queued → all outputs return to reset values immediately; after release, no responses appear and o_flags = 0.
